seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Time-multiplexed scan controller for a bank of common-anode seven-segment
// digits. One external BCD-to-segment decoder is shared across all digit
// positions. Each position gets one refresh slot of DIV_CYCLES clocks, and
// the first BLANK_CYCLES clocks of every slot keep all anodes dark.
// New display values are staged and committed only at a frame boundary, or
// straight away while scanning is disabled, so a frame never mixes old and
// new digits.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   en         scan enable; while low, the slot timer holds and the anodes are dark
//   lz_en      leading-zero suppression enable
//   ld_valid   producer offers ld_data
//   ld_ready   controller can accept a value (~pend)
//   ld_data    packed BCD, digit i on [4i+3:4i], digit 0 least significant
//   bcd_out    BCD code of the digit currently selected (to the decoder)
//   an         active-low one-hot anode select
//   frame_done one-cycle pulse after staged data is committed
//
// Load handshake: a transfer happens on every rising edge where
// ld_valid & ld_ready are both 1. ld_data only needs to be stable in that
// cycle. ld_ready stays low until the staged value is committed.
// The producer may hold ld_valid high while ld_ready is low.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int DIV_CYCLES   = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    lz_en,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [4*NUM_DIGITS-1:0] ld_data,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]         cnt, cnt_nx;
    logic [IW-1:0]         idx, idx_nx;
    logic [DW-1:0]         disp, disp_nx;
    logic [DW-1:0]         staging, staging_nx;
    logic                  pend, pend_nx;
    logic [NUM_DIGITS-1:0] an_nx;
    logic [3:0]            bcd_nx;

    logic                  accept;
    logic                  slot_end;
    logic                  frame_end;
    logic                  commit;
    logic                  zero_run;   // this digit and all higher digits are 0
    logic                  sel_zero;
    logic                  show;

    assign ld_ready = ~pend;

    always_comb begin
        accept    = ld_valid & ~pend;
        slot_end  = en && (cnt == CNT_LAST);
        frame_end = slot_end && (idx == IDX_LAST);
        // A dark display cannot show a torn frame, so commit at once when disabled.
        commit    = pend && (frame_end || !en);

        cnt_nx = cnt;
        idx_nx = idx;
        if (slot_end) begin
            cnt_nx = '0;
            idx_nx = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else if (en) begin
            cnt_nx = cnt + 1'b1;
        end

        staging_nx = accept ? ld_data : staging;
        disp_nx    = commit ? staging : disp;
        pend_nx    = pend;
        if (commit) begin
            pend_nx = 1'b0;
        end else if (accept) begin
            pend_nx = 1'b1;
        end

        // Walk from the most significant digit down so zero_run is valid
        // for the digit being selected.
        bcd_nx   = '0;
        sel_zero = 1'b0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (disp_nx[4*i +: 4] == 4'd0);
            if (idx_nx == IW'(i)) begin
                bcd_nx   = disp_nx[4*i +: 4];
                sel_zero = zero_run;
            end
        end

        // Outputs are computed from next state so they move with cnt/idx.
        show = en && (cnt_nx >= CNT_BLANK) && (bcd_nx <= 4'd9)
               && !(lz_en && (idx_nx != '0) && sel_zero);
        an_nx = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (show && (idx_nx == IW'(i))) begin
                an_nx[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            disp       <= '0;
            staging    <= '0;
            pend       <= 1'b0;
            an         <= '1;
            bcd_out    <= '0;
            frame_done <= 1'b0;
        end else begin
            cnt        <= cnt_nx;
            idx        <= idx_nx;
            disp       <= disp_nx;
            staging    <= staging_nx;
            pend       <= pend_nx;
            an         <= an_nx;
            bcd_out    <= bcd_nx;
            frame_done <= commit;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with NUM_DIGITS=4, DIV_CYCLES=8, BLANK_CYCLES=2.
// Edges are counted from the first rising edge after reset release, which is
// edge 1. Inputs are driven and outputs sampled 1ns after a rising edge.
// Slot geometry: cnt = edge % 8 and idx = (edge / 8) % 4. A full frame is
// 32 edges.
module tb_seg_scan_ctrl;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b1;
    logic          lz_en = 1'b0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [4*N-1:0] ld_data = '0;
    logic [3:0]    bcd_out;
    logic [N-1:0]  an;
    logic          frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;
    int fd_count = 0;
    int fd_base;
    logic [N-1:0] low_seen;

    typedef struct {
        int         edge_no;
        logic       lz;
        logic [3:0] an;
        logic [3:0] bcd;
    } vec_t;

    vec_t scan_tbl[18];

    seg_scan_ctrl #(
        .NUM_DIGITS(N),
        .DIV_CYCLES(8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .lz_en(lz_en),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .ld_data(ld_data),
        .bcd_out(bcd_out),
        .an(an),
        .frame_done(frame_done)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) fd_count++;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %h expected %h", nm, edge_n, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            edge_n++;
        end
    endtask

    task automatic goto_edge(input int e);
        step(e - edge_n);
    endtask

    // Called 1ns after a rising edge. The reset is checked before any edge arrives.
    task automatic do_reset();
        rst_n    = 1'b0;
        ld_valid = 1'b0;
        en       = 1'b1;
        lz_en    = 1'b0;
        #2;
        chk("rst_an", 16'(an), 16'hf);
        chk("rst_bcd", 16'(bcd_out), 16'h0);
        chk("rst_ready", 16'(ld_ready), 16'h1);
        chk("rst_fd", 16'(frame_done), 16'h0);
        #2;
        rst_n  = 1'b1;
        edge_n = 0;
    endtask

    // Offer data so that it is accepted at edge 2, then run to the commit at edge 32.
    task automatic load_frame(input logic [15:0] d);
        goto_edge(1);
        ld_valid = 1'b1;
        ld_data  = d;
        step(1);
        ld_valid = 1'b0;
        chk("ld_ready_low", 16'(ld_ready), 16'h0);
        goto_edge(32);
        chk("commit_fd", 16'(frame_done), 16'h1);
        chk("commit_bcd0", 16'(bcd_out), 16'(d[3:0]));
    endtask

    // ---------------- test ----------------
    initial begin
        scan_tbl[0]  = '{1,  1'b0, 4'b1111, 4'h0};
        scan_tbl[1]  = '{2,  1'b0, 4'b1110, 4'h0};
        scan_tbl[2]  = '{7,  1'b0, 4'b1110, 4'h0};
        scan_tbl[3]  = '{8,  1'b0, 4'b1111, 4'h0};
        scan_tbl[4]  = '{9,  1'b0, 4'b1111, 4'h0};
        scan_tbl[5]  = '{10, 1'b0, 4'b1101, 4'h0};
        scan_tbl[6]  = '{15, 1'b0, 4'b1101, 4'h0};
        scan_tbl[7]  = '{16, 1'b0, 4'b1111, 4'h0};
        scan_tbl[8]  = '{18, 1'b0, 4'b1011, 4'h0};
        scan_tbl[9]  = '{26, 1'b0, 4'b0111, 4'h0};
        scan_tbl[10] = '{31, 1'b0, 4'b0111, 4'h0};
        scan_tbl[11] = '{32, 1'b0, 4'b1111, 4'h0};
        scan_tbl[12] = '{34, 1'b0, 4'b1110, 4'h0};
        scan_tbl[13] = '{35, 1'b1, 4'b1110, 4'h0};
        scan_tbl[14] = '{42, 1'b1, 4'b1111, 4'h0};
        scan_tbl[15] = '{50, 1'b1, 4'b1111, 4'h0};
        scan_tbl[16] = '{58, 1'b1, 4'b1111, 4'h0};
        scan_tbl[17] = '{60, 1'b0, 4'b0111, 4'h0};

        @(posedge clk);
        #1;
        do_reset();

        // Scan order on an all-zero display, with lz_en toggled part way through.
        for (int i = 0; i < 18; i++) begin
            lz_en = scan_tbl[i].lz;
            goto_edge(scan_tbl[i].edge_no);
            chk("scan_an", 16'(an), 16'(scan_tbl[i].an));
            chk("scan_bcd", 16'(bcd_out), 16'(scan_tbl[i].bcd));
            chk("scan_ready", 16'(ld_ready), 16'h1);
            chk("scan_fd", 16'(frame_done), 16'h0);
        end

        // Load 16'h1234 mid-frame: offered at edge 10, accepted at edge 11.
        do_reset();
        goto_edge(10);
        ld_valid = 1'b1;
        ld_data  = 16'h1234;
        step(1);
        ld_valid = 1'b0;
        fd_base  = fd_count;
        chk("mid_ready", 16'(ld_ready), 16'h0);
        goto_edge(31);
        chk("mid_old_bcd", 16'(bcd_out), 16'h0);
        chk("mid_fd_early", 16'(frame_done), 16'h0);
        goto_edge(32);
        chk("mid_fd", 16'(frame_done), 16'h1);
        chk("mid_bcd0", 16'(bcd_out), 16'h4);
        chk("mid_ready_back", 16'(ld_ready), 16'h1);
        goto_edge(33);
        chk("mid_fd_once", 16'(frame_done), 16'h0);
        goto_edge(34);
        chk("mid_an0", 16'(an), 16'b1110);
        goto_edge(42);
        chk("mid_an1", 16'(an), 16'b1101);
        chk("mid_bcd1", 16'(bcd_out), 16'h3);
        goto_edge(50);
        chk("mid_bcd2", 16'(bcd_out), 16'h2);
        goto_edge(58);
        chk("mid_an3", 16'(an), 16'b0111);
        chk("mid_bcd3", 16'(bcd_out), 16'h1);
        goto_edge(64);
        chk("mid_fd_count", 16'(fd_count - fd_base), 16'h1);

        // Back-to-back loads: the second waits for the first commit.
        do_reset();
        goto_edge(10);
        ld_valid = 1'b1;
        ld_data  = 16'h1234;
        step(1);
        ld_data  = 16'h5678;
        goto_edge(31);
        chk("b2b_hold_ready", 16'(ld_ready), 16'h0);
        goto_edge(32);
        chk("b2b_fd1", 16'(frame_done), 16'h1);
        chk("b2b_ready_back", 16'(ld_ready), 16'h1);
        chk("b2b_bcd_first", 16'(bcd_out), 16'h4);
        step(1);
        ld_valid = 1'b0;
        chk("b2b_second_acc", 16'(ld_ready), 16'h0);
        goto_edge(63);
        chk("b2b_bcd3_old", 16'(bcd_out), 16'h1);
        chk("b2b_fd_wait", 16'(frame_done), 16'h0);
        goto_edge(64);
        chk("b2b_fd2", 16'(frame_done), 16'h1);
        chk("b2b_bcd_new", 16'(bcd_out), 16'h8);
        goto_edge(66);
        chk("b2b_an0", 16'(an), 16'b1110);
        chk("b2b_bcd0", 16'(bcd_out), 16'h8);

        // Leading-zero suppression on 16'h0050.
        do_reset();
        lz_en = 1'b1;
        load_frame(16'h0050);
        low_seen = '0;
        for (int e = 33; e <= 63; e++) begin
            step(1);
            low_seen = low_seen | ~an;
            if (e == 34) begin
                chk("lz_an0", 16'(an), 16'b1110);
                chk("lz_bcd0", 16'(bcd_out), 16'h0);
            end
            if (e == 42) begin
                chk("lz_an1", 16'(an), 16'b1101);
                chk("lz_bcd1", 16'(bcd_out), 16'h5);
            end
            if (e == 50) chk("lz_an2", 16'(an), 16'b1111);
            if (e == 58) chk("lz_an3", 16'(an), 16'b1111);
        end
        chk("lz_low_seen", 16'(low_seen), 16'b0011);

        // An invalid code in digit 1 keeps that anode dark. The other digits
        // display normally.
        do_reset();
        load_frame(16'h12A4);
        low_seen = '0;
        for (int e = 33; e <= 63; e++) begin
            step(1);
            low_seen = low_seen | ~an;
            if (e == 34) chk("inv_an0", 16'(an), 16'b1110);
            if (e == 42) begin
                chk("inv_an1", 16'(an), 16'b1111);
                chk("inv_bcd1", 16'(bcd_out), 16'hA);
            end
            if (e == 50) begin
                chk("inv_an2", 16'(an), 16'b1011);
                chk("inv_bcd2", 16'(bcd_out), 16'h2);
            end
        end
        chk("inv_low_seen", 16'(low_seen), 16'b1101);

        // en=0 at idx=2, cnt=5 with a pending load, then a load while disabled,
        // then resume.
        do_reset();
        goto_edge(20);
        ld_valid = 1'b1;
        ld_data  = 16'h9876;
        step(1);
        ld_valid = 1'b0;
        chk("en_an_live", 16'(an), 16'b1011);
        en = 1'b0;
        step(1);
        chk("en_off_an", 16'(an), 16'b1111);
        chk("en_off_fd", 16'(frame_done), 16'h1);
        chk("en_off_bcd", 16'(bcd_out), 16'h8);
        chk("en_off_ready", 16'(ld_ready), 16'h1);
        ld_valid = 1'b1;
        ld_data  = 16'h4321;
        step(1);
        ld_valid = 1'b0;
        chk("en_off_acc", 16'(ld_ready), 16'h0);
        chk("en_off_fd_gap", 16'(frame_done), 16'h0);
        step(1);
        chk("en_off_fd2", 16'(frame_done), 16'h1);
        chk("en_off_bcd2", 16'(bcd_out), 16'h3);
        goto_edge(26);
        chk("en_off_dark", 16'(an), 16'b1111);
        en = 1'b1;
        step(1);
        chk("en_resume_an", 16'(an), 16'b1011);
        chk("en_resume_bcd", 16'(bcd_out), 16'h3);
        goto_edge(29);
        chk("en_resume_blank", 16'(an), 16'b1111);
        chk("en_resume_bcd3", 16'(bcd_out), 16'h4);
        goto_edge(31);
        chk("en_resume_an3", 16'(an), 16'b0111);

        // Async reset mid-slot discards a pending value.
        ld_valid = 1'b1;
        ld_data  = 16'h1111;
        step(1);
        ld_valid = 1'b0;
        chk("pre_rst_pend", 16'(ld_ready), 16'h0);
        do_reset();
        goto_edge(32);
        chk("post_rst_fd", 16'(frame_done), 16'h0);
        goto_edge(34);
        chk("post_rst_an", 16'(an), 16'b1110);
        chk("post_rst_bcd", 16'(bcd_out), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
